updi_phy_seq: RTL

UPDI_PHY_SEQ -- requirements
Module: updi_phy_seq

---
 rtl/updi_phy_pkg.sv | 22 ++
 rtl/updi_tmo_cnt.sv | 25 ++
 rtl/updi_phy_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/updi_phy_pkg.sv
// Shared types and encodings for the UPDI PHY transaction sequencer.
// Holds the state enum, command op codes and error cause codes.
package updi_phy_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_TX_ARM, S_TX_RUN, S_RX_ARM, S_RX_RUN, S_DONE, S_ERR
  } state_e;

  localparam logic [1:0] OP_TX   = 2'b01;
  localparam logic [1:0] OP_RX   = 2'b10;
  localparam logic [1:0] OP_TXRX = 2'b11;

  localparam logic [1:0] EC_NONE    = 2'b00;
  localparam logic [1:0] EC_TX_TMO  = 2'b01;
  localparam logic [1:0] EC_RX_TMO  = 2'b10;
  localparam logic [1:0] EC_ILLEGAL = 2'b11;

  function automatic logic is_wait(state_e s);
    return s inside {S_TX_ARM, S_TX_RUN, S_RX_ARM, S_RX_RUN};
  endfunction

endpackage

// File: rtl/updi_tmo_cnt.sv
// Per-state wait timeout counter; saturates at TIMEOUT-1 and flags expiry there.
module updi_tmo_cnt #(
  parameter int TIMEOUT = 2048,
  parameter int CNT_W   = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                        r_cnt <= '0;
    else if (clear)                  r_cnt <= '0;
    else if (enable && r_cnt != LAST) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign expired = (r_cnt == LAST);

endmodule

// File: rtl/updi_phy_seq.sv
// UPDI PHY transaction sequencer: hands the buffer to the loader, walks TX/RX
// enables against the loader busy flags and reports done or a timed-out/illegal op.
module updi_phy_seq
  import updi_phy_pkg::*;
#(
  parameter int TIMEOUT = 2048,
  parameter int CNT_W   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       ten_n,
  output logic       ren_n,
  input  logic       tend,
  input  logic       rend,
  output logic       mem_sel,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  state_e     r_state;
  state_e     w_nxt;
  logic [1:0] r_op;
  logic       w_wait;
  logic       w_step;
  logic       w_exp;

  // Each wait state only looks at its own busy flag: ARM waits for the rise, RUN for the fall.
  always_comb begin
    w_wait = is_wait(r_state);
    w_step = 1'b0;
    case (r_state)
      S_TX_ARM: w_step = tend;
      S_TX_RUN: w_step = ~tend;
      S_RX_ARM: w_step = rend;
      S_RX_RUN: w_step = ~rend;
      default:  w_step = 1'b0;
    endcase
  end

  updi_tmo_cnt #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (~w_wait | w_step | w_exp),
    .enable  (w_wait),
    .expired (w_exp)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (cmd_valid) begin
          case (cmd_op)
            OP_TX, OP_TXRX: w_nxt = S_TX_ARM;
            OP_RX:          w_nxt = S_RX_ARM;
            default:        w_nxt = S_ERR;
          endcase
        end
      S_TX_ARM, S_TX_RUN, S_RX_ARM, S_RX_RUN:
        if (w_exp) w_nxt = S_ERR;
        else if (w_step) begin
          case (r_state)
            S_TX_ARM: w_nxt = S_TX_RUN;
            S_TX_RUN: w_nxt = (r_op == OP_TXRX) ? S_RX_ARM : S_DONE;
            S_RX_ARM: w_nxt = S_RX_RUN;
            default:  w_nxt = S_DONE;
          endcase
        end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_op      <= 2'b00;
      cmd_ready <= 1'b1;
      ten_n     <= 1'b1;
      ren_n     <= 1'b1;
      mem_sel   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= EC_NONE;
    end else begin
      r_state   <= w_nxt;
      cmd_ready <= (w_nxt == S_IDLE);
      ten_n     <= ~(w_nxt inside {S_TX_ARM, S_TX_RUN});
      ren_n     <= ~(w_nxt inside {S_RX_ARM, S_RX_RUN});
      mem_sel   <= is_wait(w_nxt);
      done      <= (w_nxt == S_DONE);
      err       <= (w_nxt == S_ERR);
      if (r_state == S_IDLE && cmd_valid) begin
        r_op     <= cmd_op;
        err_code <= (cmd_op == 2'b00) ? EC_ILLEGAL : EC_NONE;
      end else if (w_wait && w_nxt == S_ERR) begin
        err_code <= (r_state inside {S_TX_ARM, S_TX_RUN}) ? EC_TX_TMO : EC_RX_TMO;
      end
    end
  end

endmodule
